mult_div_unit: RTL

//   Parametrised multi-cycle integer multiply/divide unit for the CPU datapath; next generation of the HI/LO mult/div block.

---
 rtl/mult_div_unit.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle signed/unsigned integer multiply/divide for the
// CPU datapath, writing the 2*WIDTH product or the remainder/quotient pair to
// HI/LO with a start/busy/done handshake.
//
// Build option: define MULDIV_DIV0_FASTEXIT_EN to let a divide by zero finish
// straight out of LOAD (two-cycle latency). Results are identical either way.
//
// Timing, counting the edge that accepts start as edge N:
//   cycle N+1           LOAD  (busy)
//   cycles N+2..N+W+1   CALC  (busy, one bit per cycle)
//   cycle N+W+2         FIX   (done, hi/lo/div_by_zero already updated)
// The last CALC step and the sign fix-up share one edge so that the result
// registers are valid in the same cycle that done is high.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t state, state_nx;

    // Operands captured when start is accepted; b_q is replaced by |b| in LOAD,
    // a_q keeps the raw dividend for the divide-by-zero result.
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             neg_q;
    logic             neg_r;
    logic             div0_q;
    logic [CW-1:0]    cnt;
    // Multiply: [2W:W] partial sum, [W-1:0] multiplier shifting out.
    // Divide:   [2W-1:W] partial remainder, [W-1:0] dividend -> quotient.
    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_step;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             dbz_q;

    logic             accept;
    logic             signed_op;
    logic             load_div0;
    logic             last_step;
    logic             fast_exit;

    // Absolute value for signed ops; MIN maps onto 2^(W-1) read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(
        input logic signed [WIDTH-1:0] v,
        input logic                    is_signed
    );
        if (is_signed && v[WIDTH-1]) begin
            return -v;
        end
        return v;
    endfunction

    // One shift-add multiply step: add the multiplicand when the current
    // multiplier LSB is set, then shift the whole accumulator right.
    function automatic logic [AW-1:0] mul_step(
        input logic [AW-1:0]    acc_i,
        input logic [WIDTH-1:0] mcand
    );
        logic [WIDTH:0] upper;
        upper = acc_i[AW-1:WIDTH];
        if (acc_i[0]) begin
            upper = upper + {1'b0, mcand};
        end
        return {1'b0, upper, acc_i[WIDTH-1:1]};
    endfunction

    // One restoring-division step: bring in the next dividend bit, trial
    // subtract on W+1 bits and keep the old remainder when it borrows.
    function automatic logic [AW-1:0] div_step(
        input logic [WIDTH-1:0] rem_i,
        input logic [WIDTH-1:0] dvd_i,
        input logic [WIDTH-1:0] dvsr
    );
        logic [WIDTH:0]   rem_sh;
        logic [WIDTH:0]   trial;
        logic [WIDTH-1:0] rem_n;
        rem_sh = {rem_i, dvd_i[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvsr};
        rem_n  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        return {1'b0, rem_n, dvd_i[WIDTH-2:0], ~trial[WIDTH]};
    endfunction

    // Sign fix-up and divide-by-zero substitution; returns {hi, lo}.
    function automatic logic [2*WIDTH-1:0] fix_result(
        input logic [2*WIDTH-1:0] res,
        input logic [1:0]         op_i,
        input logic               nq,
        input logic               nr,
        input logic               dz,
        input logic [WIDTH-1:0]   dividend
    );
        logic signed [2*WIDTH-1:0] prod;
        logic signed [WIDTH-1:0]   quo;
        logic signed [WIDTH-1:0]   rem;
        if (!op_i[1]) begin
            prod = res;
            if (!op_i[0] && nq) begin
                prod = -prod;
            end
            return prod;
        end
        if (dz) begin
            return {dividend, {WIDTH{1'b1}}};
        end
        quo = res[WIDTH-1:0];
        rem = res[2*WIDTH-1:WIDTH];
        if (!op_i[0]) begin
            if (nq) begin
                quo = -quo;
            end
            if (nr) begin
                rem = -rem;
            end
        end
        return {rem, quo};
    endfunction

    assign accept    = (state == IDLE) && start && !done_q;
    assign signed_op = ~op_q[0];
    assign load_div0 = op_q[1] && (b_q == '0);
    assign last_step = (state == CALC) && (cnt == '0);
    assign acc_step  = op_q[1] ? div_step(acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:0], b_q)
                               : mul_step(acc, b_q);

`ifdef MULDIV_DIV0_FASTEXIT_EN
    assign fast_exit = (state == LOAD) && load_div0;
`else
    assign fast_exit = 1'b0;
`endif

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                state_nx = fast_exit ? IDLE : CALC;
            end
            CALC: begin
                if (cnt == '0) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath, and result/handshake registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0_q <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= op;
                        a_q    <= a;
                        b_q    <= b;
                        busy_q <= 1'b1;
                    end
                end
                LOAD: begin
                    neg_q  <= signed_op && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_r  <= signed_op && a_q[WIDTH-1];
                    div0_q <= load_div0;
                    b_q    <= magnitude(b_q, signed_op);
                    acc    <= {{(WIDTH+1){1'b0}}, magnitude(a_q, signed_op)};
                    cnt    <= CW'(WIDTH - 1);
                    if (fast_exit) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        hi_q   <= a_q;
                        lo_q   <= '1;
                        dbz_q  <= 1'b1;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt - 1'b1;
                    if (last_step) begin
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        {hi_q, lo_q} <= fix_result(acc_step[2*WIDTH-1:0], op_q,
                                                   neg_q, neg_r, div0_q, a_q);
                        dbz_q        <= div0_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule
